// File: rtl/pie_tx_pkg.sv
// Package: pie_tx_pkg
// Shared state encoding, CRC-16 constants and symbol-length helpers for the
// Gen2 PIE transmit encoder.
package pie_tx_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DELIM = 3'd1,
        DATA0 = 3'd2,
        RTCAL = 3'd3,
        TRCAL = 3'd4,
        BITS  = 3'd5,
        CRC   = 3'd6
    } pie_state_e;

    localparam logic [15:0] CRC16_POLY   = 16'h1021;
    localparam logic [15:0] CRC16_PRESET = 16'hFFFF;

    // Data-0 symbol length equals one Tari.
    function automatic int data0_len(input int tari);
        return tari;
    endfunction

    // Data-1 symbol length is two Tari.
    function automatic int data1_len(input int tari);
        return 2 * tari;
    endfunction

    // RTcal is data-0 plus data-1, i.e. three Tari.
    function automatic int rtcal_len(input int tari);
        return 3 * tari;
    endfunction

endpackage

// File: rtl/pie_tx_encoder_if.sv
// Interface: pie_tx_encoder_if
// Command/launch bus into the PIE encoder plus the envelope and status back.
// The master side is the command source, the slave side is the encoder.
interface pie_tx_encoder_if #(
    parameter int MAX_BITS = 128,
    parameter int TRCAL_W  = 9
);
    localparam int LEN_W = $clog2(MAX_BITS + 1);

    logic                tick;
    logic                start;
    logic                preamble_sel;
    logic [MAX_BITS-1:0] cmd_dat;
    logic [LEN_W-1:0]    cmd_len;
    logic [TRCAL_W-1:0]  trcal_ticks;
    logic                tx_dat;
    logic                busy;
    logic                done;

    modport master (
        output tick, start, preamble_sel, cmd_dat, cmd_len, trcal_ticks,
        input  tx_dat, busy, done
    );

    modport slave (
        input  tick, start, preamble_sel, cmd_dat, cmd_len, trcal_ticks,
        output tx_dat, busy, done
    );

endinterface

// File: rtl/crc16_serial.sv
// Module: crc16_serial
// Bit-serial CRC-16 (poly 0x1021, preset 0xFFFF, inverted output), MSB-first.
module crc16_serial
    import pie_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic        bit_in,
    output logic [15:0] crc_out
);

    logic [15:0] crc_q, crc_d;
    logic        fb;

    // One shift of the LFSR with the incoming message bit folded into the feedback.
    always_comb begin
        fb    = crc_q[15] ^ bit_in;
        crc_d = {crc_q[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    end

    // Preset on reset or frame start, advance once per consumed message bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q <= CRC16_PRESET;
        end else if (clr) begin
            crc_q <= CRC16_PRESET;
        end else if (en) begin
            crc_q <= crc_d;
        end
    end

    assign crc_out = ~crc_q;

endmodule

// File: rtl/pie_tx_encoder.sv
// Module: pie_tx_encoder
// Reader-to-tag PIE envelope generator: delimiter, data-0, RTcal, optional
// TRcal, then the command bits. Optional CRC-16 tail under PIE_TX_CRC16_EN.
// tx_dat always shows the envelope level of the tick that is about to be
// consumed, so it only moves on consumed ticks (and on frame acceptance).
module pie_tx_encoder
    import pie_tx_pkg::*;
#(
    parameter int TARI_TICKS  = 25,
    parameter int PW_TICKS    = 12,
    parameter int DELIM_TICKS = 50,
    parameter int MAX_BITS    = 128,
    parameter int TRCAL_W     = 9
) (
    input  logic            clk,
    input  logic            rst,
    pie_tx_encoder_if.slave bus
);

    localparam int LEN_W = $clog2(MAX_BITS + 1);
    localparam int CNT_W = 16;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t LEN_DELIM = cnt_t'(DELIM_TICKS);
    localparam cnt_t LEN_D0    = cnt_t'(data0_len(TARI_TICKS));
    localparam cnt_t LEN_D1    = cnt_t'(data1_len(TARI_TICKS));
    localparam cnt_t LEN_RT    = cnt_t'(rtcal_len(TARI_TICKS));
    localparam cnt_t LEN_PW    = cnt_t'(PW_TICKS);
    localparam logic [TRCAL_W-1:0] TRCAL_MIN = TRCAL_W'(PW_TICKS + 1);

    pie_state_e          state_q, state_d;
    pie_state_e          tail_st, post_pre_st;
    cnt_t                cnt_q, cnt_d;
    cnt_t                sym_len;
    logic [LEN_W-1:0]    bits_q, bits_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                tx_q, tx_d;
    logic                pre_q;
    logic [TRCAL_W-1:0]  trcal_q;
    logic [MAX_BITS-1:0] sh_q;
    logic                accept;
    logic                sym_end;
    logic                shift_en;
    logic                cur_bit;

    assign accept   = bus.start && !busy_q;
    assign sym_end  = (cnt_q == sym_len - cnt_t'(1));
    assign shift_en = bus.tick && (state_q == BITS) && sym_end;

`ifdef PIE_TX_CRC16_EN
    logic [3:0]  crc_idx_q, crc_idx_d;
    logic [15:0] crc_val;

    crc16_serial u_crc (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept),
        .en      (shift_en),
        .bit_in  (sh_q[MAX_BITS-1]),
        .crc_out (crc_val)
    );
`endif

    // Bit currently being sent: command MSB, or the selected CRC bit in the tail.
    always_comb begin
        cur_bit = sh_q[MAX_BITS-1];
`ifdef PIE_TX_CRC16_EN
        if (state_q == CRC) begin
            cur_bit = crc_val[crc_idx_q];
        end
`endif
    end

    // Length in ticks of the symbol occupying the current state.
    always_comb begin
        case (state_q)
            DELIM:     sym_len = LEN_DELIM;
            DATA0:     sym_len = LEN_D0;
            RTCAL:     sym_len = LEN_RT;
            TRCAL:     sym_len = cnt_t'(trcal_q);
            BITS, CRC: sym_len = cur_bit ? LEN_D1 : LEN_D0;
            default:   sym_len = LEN_D0;
        endcase
    end

    // Where the frame goes after the preamble and after the last command bit.
    always_comb begin
`ifdef PIE_TX_CRC16_EN
        tail_st = CRC;
`else
        tail_st = IDLE;
`endif
        if (bits_q != '0) begin
            post_pre_st = BITS;
        end else begin
            post_pre_st = tail_st;
        end
    end

    // Frame sequencing: advance one tick position per strobe, hop states at symbol ends.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bits_d  = bits_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        tx_d    = tx_q;
`ifdef PIE_TX_CRC16_EN
        crc_idx_d = crc_idx_q;
`endif
        if (accept) begin
            state_d = DELIM;
            cnt_d   = '0;
            bits_d  = bus.cmd_len;
            busy_d  = 1'b1;
            tx_d    = 1'b0;
`ifdef PIE_TX_CRC16_EN
            crc_idx_d = 4'd15;
`endif
        end else if (busy_q && bus.tick) begin
            if (!sym_end) begin
                cnt_d = cnt_q + cnt_t'(1);
                tx_d  = (state_q != DELIM) && (cnt_d < sym_len - LEN_PW);
            end else begin
                cnt_d = '0;
                tx_d  = 1'b1;
                case (state_q)
                    DELIM: state_d = DATA0;
                    DATA0: state_d = RTCAL;
                    RTCAL: begin
                        if (pre_q) begin
                            state_d = TRCAL;
                        end else begin
                            state_d = post_pre_st;
                        end
                    end
                    TRCAL: state_d = post_pre_st;
                    BITS: begin
                        bits_d = bits_q - LEN_W'(1);
                        if (bits_q == LEN_W'(1)) begin
                            state_d = tail_st;
                        end
                    end
`ifdef PIE_TX_CRC16_EN
                    CRC: begin
                        crc_idx_d = crc_idx_q - 4'd1;
                        if (crc_idx_q == 4'd0) begin
                            state_d = IDLE;
                        end
                    end
`endif
                    default: state_d = IDLE;
                endcase
                if (state_d == IDLE) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
            end
        end
    end

    // Control state; an asynchronous reset aborts any frame and returns to CW.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bits_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tx_q    <= 1'b1;
`ifdef PIE_TX_CRC16_EN
            crc_idx_q <= 4'd0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bits_q  <= bits_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tx_q    <= tx_d;
`ifdef PIE_TX_CRC16_EN
            crc_idx_q <= crc_idx_d;
`endif
        end
    end

    // Frame parameters captured at acceptance; command left-aligned so the MSB is next out.
    always_ff @(posedge clk) begin
        if (accept) begin
            pre_q   <= bus.preamble_sel;
            trcal_q <= (bus.trcal_ticks < TRCAL_MIN) ? TRCAL_MIN : bus.trcal_ticks;
            sh_q    <= bus.cmd_dat << (LEN_W'(MAX_BITS) - bus.cmd_len);
        end else if (shift_en) begin
            sh_q <= {sh_q[MAX_BITS-2:0], 1'b0};
        end
    end

    assign bus.tx_dat = tx_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

endmodule
